arbitro_banco: RTL



---
 rtl/arbitro_banco.sv | 109 ++++++++++
 1 files changed

// File: rtl/arbitro_banco.sv
`timescale 1ns/1ps
// Round-robin write-port arbiter for the 32x32 register bank: two one-entry writeback slots,
// one registered bank write per cycle, read hazard flags. Define ZERO_REG_EN for a hard-wired r0.
module arbitro_banco #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v0,
  output logic              rdy0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  input  logic              v1,
  output logic              rdy1,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              haz1,
  output logic              haz2
);

`ifdef ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              rr;
  logic              grant0, grant1;
  logic              acc0, acc1;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;

  // rr only breaks ties; a lone full slot always wins.
  always_comb begin
    grant0 = full0 && (!full1 || !rr);
    grant1 = full1 && (!full0 || rr);
    gaddr  = grant1 ? addr1 : addr0;
    gdata  = grant1 ? data1 : data0;
  end

  assign rdy0 = !full0 || grant0;
  assign rdy1 = !full1 || grant1;
  assign acc0 = v0 && rdy0;
  assign acc1 = v1 && rdy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0 <= 1'b0;
      addr0 <= '0;
      data0 <= '0;
    end else if (acc0) begin
      full0 <= 1'b1;
      addr0 <= a0;
      data0 <= d0;
    end else if (grant0) begin
      full0 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full1 <= 1'b0;
      addr1 <= '0;
      data1 <= '0;
    end else if (acc1) begin
      full1 <= 1'b1;
      addr1 <= a1;
      data1 <= d1;
    end else if (grant1) begin
      full1 <= 1'b0;
    end
  end

  // A granted r0 entry is still consumed when r0 is hard-wired; only the strobe is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr      <= 1'b0;
    end else if (grant0 || grant1) begin
      wr_en   <= !(ZERO_EN && (gaddr == '0));
      wr_addr <= gaddr;
      wr_data <= gdata;
      rr      <= grant0;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  assign haz1 = ((full0 && (addr0 == rd_addr1)) ||
                 (full1 && (addr1 == rd_addr1)) ||
                 (wr_en && (wr_addr == rd_addr1))) &&
                !(ZERO_EN && (rd_addr1 == '0));
  assign haz2 = ((full0 && (addr0 == rd_addr2)) ||
                 (full1 && (addr1 == rd_addr2)) ||
                 (wr_en && (wr_addr == rd_addr2))) &&
                !(ZERO_EN && (rd_addr2 == '0));

endmodule
